// File: rtl/clock_divider_if.sv
// -----------------------------------------------------------------------------
// clock_divider_if
//   Bundles the divided core clock and the core reset that the divider
//   drives towards the CPU/SoC logic.
//
//   Signals
//     clk    divided core clock (flop output, 50% duty)
//     reset  core reset, active-high, registered in the board-clock domain
//
//   Modports
//     master  the divider: drives clk and reset
//     slave   the core side: observes clk and reset
//
//   Interface semantics: there is no valid/ready handshake on this bundle.
//   Both signals are level signals, valid on every board clock cycle once the
//   divider has been reset (or immediately with power-on initial values).
// -----------------------------------------------------------------------------
interface clock_divider_if;
    logic clk;
    logic reset;

    modport master (output clk, output reset);
    modport slave  (input  clk, input  reset);
endinterface

// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//   Derives the slow core clock and the stretched core reset from the board
//   clock. A free-running BITS-wide counter provides the core clock on its
//   MSB; the core reset stays asserted for RST_CYCLES rising core-clock edges
//   after the board reset is released and drops on a falling core-clock edge.
//
//   Parameters
//     BITS        counter width, core clock period = 2^BITS board cycles (1..32)
//     RST_CYCLES  rising core-clock edges seen with reset asserted (>= 1)
//
//   Ports
//     CLK    in   board clock, the only clock of this block
//     RESET  in   synchronous active-high reset, sampled on posedge CLK
//     core   clock_divider_if.master
//              core.clk    divided clock = counter MSB
//              core.reset  core reset, active-high
//
//   Configuration macro
//     CLKDIV_POR_EN  when defined, the state flops carry power-on values so
//                    the core reset is asserted from configuration without
//                    a RESET pulse. When undefined, outputs are unknown until
//                    RESET has been applied once.
// -----------------------------------------------------------------------------
module clock_divider #(
    parameter int BITS       = 24,
    parameter int RST_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    clock_divider_if.master   core
);

    localparam int HW = $clog2(RST_CYCLES + 1);

    localparam logic [BITS-1:0] ALL_ONES = '1;
    // Last count before the MSB goes high.
    localparam logic [BITS-1:0] RISE_CNT = ALL_ONES >> 1;

`ifdef CLKDIV_POR_EN
    logic [BITS-1:0] r_cnt   = '0;
    logic [HW-1:0]   r_hold  = HW'(RST_CYCLES);
    logic            r_rst_q = 1'b1;
`else
    logic [BITS-1:0] r_cnt;
    logic [HW-1:0]   r_hold;
    logic            r_rst_q;
`endif

    logic w_rise;
    logic w_fall;

    // The edges are decoded from the count that is about to roll into the
    // next state, so the update lands on the same board edge as the clk change.
    assign w_rise = (r_cnt == RISE_CNT);
    assign w_fall = (r_cnt == ALL_ONES);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_hold  <= HW'(RST_CYCLES);
            r_rst_q <= 1'b1;
        end else begin
            r_cnt <= r_cnt + BITS'(1);
            if (w_rise && (r_hold != '0)) begin
                r_hold <= r_hold - HW'(1);
            end
            // Release only on a falling core-clock edge so the core gets half
            // a slow period of margin before its next rising edge.
            if (w_fall && (r_hold == '0)) begin
                r_rst_q <= 1'b0;
            end
        end
    end

    assign core.clk   = r_cnt[BITS-1];
    assign core.reset = r_rst_q;

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//   Three divider instances share CLK and RESET:
//     u_a  BITS=2, RST_CYCLES=2
//     u_b  BITS=3, RST_CYCLES=3
//     u_c  BITS=1, RST_CYCLES=1
//   The reference model only tracks the number of board edges since the last
//   edge that sampled RESET high and derives clk/reset from that with plain
//   arithmetic.
// -----------------------------------------------------------------------------
module tb_clock_divider;

    logic CLK;
    logic RESET;

    clock_divider_if if_a ();
    clock_divider_if if_b ();
    clock_divider_if if_c ();

    clock_divider #(.BITS(2), .RST_CYCLES(2)) u_a (.CLK(CLK), .RESET(RESET), .core(if_a.master));
    clock_divider #(.BITS(3), .RST_CYCLES(3)) u_b (.CLK(CLK), .RESET(RESET), .core(if_b.master));
    clock_divider #(.BITS(1), .RST_CYCLES(1)) u_c (.CLK(CLK), .RESET(RESET), .core(if_c.master));

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Board edges since the last RESET-high edge; valid once the state is known.
    int  since_rst = 0;
    bit  model_valid = 1'b0;

    logic prev_clk_b;
    int   rises_b = 0;
    bit   prev_exp_rst_b = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edges since reset %0d)", tag, got, exp, since_rst);
        end
    endtask

    function automatic logic exp_clk(input int n, input int bits);
        return ((n % (1 << bits)) >= (1 << (bits - 1)));
    endfunction

    function automatic logic exp_rst(input int n, input int bits, input int rc);
        return (n < rc * (1 << bits));
    endfunction

    task automatic check_all();
        logic eb;
        check_val("a_clk",   {31'd0, if_a.clk},   {31'd0, exp_clk(since_rst, 2)});
        check_val("a_reset", {31'd0, if_a.reset}, {31'd0, exp_rst(since_rst, 2, 2)});
        check_val("b_clk",   {31'd0, if_b.clk},   {31'd0, exp_clk(since_rst, 3)});
        check_val("b_reset", {31'd0, if_b.reset}, {31'd0, exp_rst(since_rst, 3, 3)});
        check_val("c_clk",   {31'd0, if_c.clk},   {31'd0, exp_clk(since_rst, 1)});
        check_val("c_reset", {31'd0, if_c.reset}, {31'd0, exp_rst(since_rst, 1, 1)});
        // Exactly RST_CYCLES rising core-clock edges happen while reset is high.
        eb = exp_rst(since_rst, 3, 3);
        if (prev_exp_rst_b && !eb) begin
            check_val("b_rises_in_reset", rises_b, 3);
        end
        prev_exp_rst_b = eb;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic rst);
        RESET = rst;
        @(posedge CLK);
        if (rst) begin
            since_rst   = 0;
            model_valid = 1'b1;
            rises_b     = 0;
        end else if (since_rst < 1000000) begin
            since_rst++;
        end
        #1;
        if (!prev_clk_b && if_b.clk && if_b.reset) rises_b++;
        prev_clk_b = if_b.clk;
        if (model_valid) check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET      = 1'b0;
        prev_clk_b = 1'b0;
`ifdef CLKDIV_POR_EN
        model_valid    = 1'b1;
        prev_exp_rst_b = 1'b1;
        #1;
        check_all();
        run(40);
`else
        run(3);
`endif
        // Single-cycle reset, then past every release point.
        hold_reset(1);
        run(40);
        // Mid-run reassertion after reset already released.
        hold_reset(1);
        run(29);
        hold_reset(1);
        run(30);
        // Long reset pulse.
        hold_reset(10);
        run(40);
        // Random pulses and run lengths.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 4) == 0) hold_reset(10);
            else hold_reset($urandom_range(1, 4));
            run($urandom_range(0, 50));
        end
        run(30);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
